// File: rtl/conv_chunk_scheduler.sv
// Sequences N_chunks compute->store iterations of one conv layer over NBUF output buffers,
// issuing single-cycle, index-tagged compute/store commands in the cycle of the trigger.
module conv_chunk_scheduler #(
    parameter int unsigned CW   = 16,
    parameter int unsigned NBUF = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] N_chunks,
    input  logic          conv_start,
    input  logic          conv_compute_fin,
    input  logic          conv_store_fin,
    output logic          conv_compute,
    output logic [CW-1:0] compute_idx,
    output logic          conv_store,
    output logic [CW-1:0] store_idx,
    output logic          conv_fin,
    output logic          busy,
    output logic          err
);
    localparam int unsigned OW = $clog2(NBUF + 1);
    localparam logic [OW-1:0] NbufW = OW'(NBUF);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        run_q, run_d;
    logic [CW-1:0] n_lat_q, n_lat_d, c_iss_q, c_iss_d, s_iss_q, s_iss_d;
    logic          c_busy_q, c_busy_d, s_busy_q, s_busy_d, err_q, err_d;
    logic [OW-1:0] pend_q, pend_d, occ_q, occ_d, occ_free;
    logic          cf, sf, st, ci, fin, spurious;

    assign cf       = conv_compute_fin & c_busy_q;
    assign sf       = conv_store_fin & s_busy_q;
    assign spurious = (conv_compute_fin & ~c_busy_q) | (conv_store_fin & ~s_busy_q);
    // Buffer count as seen after this cycle's store completion is retired.
    assign occ_free = occ_q - OW'(sf);

    assign busy = (run_q == StRun);
    assign err  = err_q;

    always_comb begin
        run_d        = run_q;
        n_lat_d      = n_lat_q;
        c_iss_d      = c_iss_q;
        s_iss_d      = s_iss_q;
        c_busy_d     = c_busy_q;
        s_busy_d     = s_busy_q;
        pend_d       = pend_q;
        occ_d        = occ_q;
        err_d        = err_q | spurious;
        st           = 1'b0;
        ci           = 1'b0;
        fin          = 1'b0;
        conv_compute = 1'b0;
        compute_idx  = '0;
        conv_store   = 1'b0;
        store_idx    = '0;
        conv_fin     = 1'b0;

        unique case (run_q)
            StIdle: begin
                if (conv_start) begin
                    err_d = spurious;
                    if (N_chunks == '0) begin
                        conv_fin = 1'b1;
                    end else begin
                        conv_compute = 1'b1;
                        n_lat_d      = N_chunks;
                        c_iss_d      = CW'(1);
                        c_busy_d     = 1'b1;
                        occ_d        = OW'(1);
                        run_d        = StRun;
                    end
                end
            end
            StRun: begin
                st  = ((pend_q != '0) | cf) & (~s_busy_q | sf);
                ci  = (c_iss_q < n_lat_q) & (~c_busy_q | cf) & (occ_free < NbufW);
                fin = sf & (s_iss_q == n_lat_q) & (pend_q == '0) & ~c_busy_q;

                conv_store   = st;
                store_idx    = st ? s_iss_q : '0;
                conv_compute = ci;
                compute_idx  = ci ? c_iss_q : '0;

                pend_d   = pend_q + OW'(cf) - OW'(st);
                occ_d    = occ_q + OW'(ci) - OW'(sf);
                c_busy_d = ci | (c_busy_q & ~cf);
                s_busy_d = st | (s_busy_q & ~sf);
                c_iss_d  = c_iss_q + CW'(ci);
                s_iss_d  = s_iss_q + CW'(st);

                if (fin) begin
                    conv_fin = 1'b1;
                    run_d    = StIdle;
                    n_lat_d  = '0;
                    c_iss_d  = '0;
                    s_iss_d  = '0;
                    c_busy_d = 1'b0;
                    s_busy_d = 1'b0;
                    pend_d   = '0;
                    occ_d    = '0;
                end
            end
            default: run_d = StIdle;
        endcase

        // Commands are suppressed while reset is held so no pulse escapes an abort.
        if (reset) begin
            conv_compute = 1'b0;
            compute_idx  = '0;
            conv_store   = 1'b0;
            store_idx    = '0;
            conv_fin     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= StIdle;
            n_lat_q  <= '0;
            c_iss_q  <= '0;
            s_iss_q  <= '0;
            c_busy_q <= 1'b0;
            s_busy_q <= 1'b0;
            pend_q   <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            run_q    <= run_d;
            n_lat_q  <= n_lat_d;
            c_iss_q  <= c_iss_d;
            s_iss_q  <= s_iss_d;
            c_busy_q <= c_busy_d;
            s_busy_q <= s_busy_d;
            pend_q   <= pend_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_conv_chunk_scheduler.sv
// Directed bench: one serial (NBUF=1) and one double-buffered (NBUF=2) scheduler share stimulus.
module tb_conv_chunk_scheduler;
    localparam int CW = 16;

    logic          clk, reset;
    logic [CW-1:0] n_chunks;
    logic          conv_start, compute_fin, store_fin;

    logic          cmp1, st1, fin1, busy1, err1;
    logic [CW-1:0] cidx1, sidx1;
    logic          cmp2, st2, fin2, busy2, err2;
    logic [CW-1:0] cidx2, sidx2;
    logic [34:0]   obs1, obs2;

    int checks = 0;
    int errors = 0;

    conv_chunk_scheduler #(.CW(CW), .NBUF(1)) dut1 (
        .clk(clk), .reset(reset), .N_chunks(n_chunks), .conv_start(conv_start),
        .conv_compute_fin(compute_fin), .conv_store_fin(store_fin),
        .conv_compute(cmp1), .compute_idx(cidx1), .conv_store(st1), .store_idx(sidx1),
        .conv_fin(fin1), .busy(busy1), .err(err1)
    );

    conv_chunk_scheduler #(.CW(CW), .NBUF(2)) dut2 (
        .clk(clk), .reset(reset), .N_chunks(n_chunks), .conv_start(conv_start),
        .conv_compute_fin(compute_fin), .conv_store_fin(store_fin),
        .conv_compute(cmp2), .compute_idx(cidx2), .conv_store(st2), .store_idx(sidx2),
        .conv_fin(fin2), .busy(busy2), .err(err2)
    );

    // Indices only matter while their pulse is high.
    assign obs1 = {cmp1, cmp1 ? cidx1 : 16'd0, st1, st1 ? sidx1 : 16'd0, fin1};
    assign obs2 = {cmp2, cmp2 ? cidx2 : 16'd0, st2, st2 ? sidx2 : 16'd0, fin2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] ev(bit c, int ci, bit s, int si, bit f);
        return {c, 16'(ci), s, 16'(si), f};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        conv_start  = 1'b0;
        compute_fin = 1'b0;
        store_fin   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (dut2.occ_q > 2 || dut2.pend_q > dut2.occ_q || dut2.s_iss_q > dut2.c_iss_q ||
                dut2.c_iss_q > dut2.n_lat_q) begin
                errors++;
                $display("FAIL invariant2: occ %0d pend %0d s_iss %0d c_iss %0d n_lat %0d",
                         dut2.occ_q, dut2.pend_q, dut2.s_iss_q, dut2.c_iss_q, dut2.n_lat_q);
            end
            checks++;
            if (int'(dut1.occ_q) > 1 || dut1.pend_q > dut1.occ_q ||
                dut1.s_iss_q > dut1.c_iss_q || dut1.c_iss_q > dut1.n_lat_q) begin
                errors++;
                $display("FAIL invariant1: occ %0d pend %0d s_iss %0d c_iss %0d n_lat %0d",
                         dut1.occ_q, dut1.pend_q, dut1.s_iss_q, dut1.c_iss_q, dut1.n_lat_q);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if ({obs2, busy2, err2} !== 37'd0) begin
            errors++;
            $display("FAIL reset2: got %h want 0", {obs2, busy2, err2});
        end
        checks++;
        if ({obs1, busy1, err1} !== 37'd0) begin
            errors++;
            $display("FAIL reset1: got %h want 0", {obs1, busy1, err1});
        end
    endtask

    task automatic test_serial();
        logic [34:0] exp;
        do_reset();
        n_chunks = 16'd3; conv_start = 1'b1; #1;
        checks++;
        if (obs1 !== ev(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL serial_c0: got %h want %h", obs1, ev(1, 0, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) begin
            repeat (4) next_cycle();
            #1;
            checks++;
            if ({obs1, busy1} !== {35'd0, 1'b1}) begin
                errors++; $display("FAIL serial_wait%0d: got %h want %h", k, {obs1, busy1}, 36'd1);
            end
            next_cycle(); compute_fin = 1'b1; #1;
            checks++;
            if (obs1 !== ev(0, 0, 1, k, 0)) begin
                errors++; $display("FAIL serial_store%0d: got %h want %h", k, obs1, ev(0, 0, 1, k, 0));
            end
            repeat (4) next_cycle();
            store_fin = 1'b1; #1;
            exp = (k < 2) ? ev(1, k + 1, 0, 0, 0) : ev(0, 0, 0, 0, 1);
            checks++;
            if (obs1 !== exp) begin
                errors++; $display("FAIL serial_sf%0d: got %h want %h", k, obs1, exp);
            end
        end
        next_cycle(); #1;
        checks++;
        if ({busy1, err1} !== 2'b00) begin
            errors++; $display("FAIL serial_end: busy/err got %b want 00", {busy1, err1});
        end
    endtask

    task automatic test_overlap();
        do_reset();
        n_chunks = 16'd3; conv_start = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL ovl_c0: got %h want %h", obs2, ev(1, 0, 0, 0, 0));
        end
        next_cycle(); next_cycle(); compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 1, 1, 0, 0)) begin
            errors++; $display("FAIL ovl_cf0: got %h want %h", obs2, ev(1, 1, 1, 0, 0));
        end
        next_cycle(); compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== 35'd0) begin
            errors++; $display("FAIL ovl_cf1_hold: got %h want 0", obs2);
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 2, 1, 1, 0)) begin
            errors++; $display("FAIL ovl_sf0: got %h want %h", obs2, ev(1, 2, 1, 1, 0));
        end
        next_cycle(); compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== 35'd0) begin
            errors++; $display("FAIL ovl_cf2: got %h want 0", obs2);
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 1, 2, 0)) begin
            errors++; $display("FAIL ovl_sf1: got %h want %h", obs2, ev(0, 0, 1, 2, 0));
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL ovl_fin: got %h want %h", obs2, ev(0, 0, 0, 0, 1));
        end
        next_cycle(); #1;
        checks++;
        if ({busy2, err2} !== 2'b00) begin
            errors++; $display("FAIL ovl_end: busy/err got %b want 00", {busy2, err2});
        end
    endtask

    task automatic test_zero_chunks();
        do_reset();
        n_chunks = 16'd0; conv_start = 1'b1; #1;
        checks++;
        if ({obs2, obs1} !== {ev(0, 0, 0, 0, 1), ev(0, 0, 0, 0, 1)}) begin
            errors++; $display("FAIL zero_fin: got %h %h want fin only", obs2, obs1);
        end
        next_cycle(); #1;
        checks++;
        if ({obs2, busy2, err2, busy1} !== 38'd0) begin
            errors++; $display("FAIL zero_idle: got %h want 0", {obs2, busy2, err2, busy1});
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        n_chunks = 16'd4; conv_start = 1'b1; #1;
        next_cycle(); compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 1, 1, 0, 0)) begin
            errors++; $display("FAIL sim_cf0: got %h want %h", obs2, ev(1, 1, 1, 0, 0));
        end
        next_cycle(); compute_fin = 1'b1; store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 2, 1, 1, 0)) begin
            errors++; $display("FAIL sim_both1: got %h want %h", obs2, ev(1, 2, 1, 1, 0));
        end
        next_cycle(); compute_fin = 1'b1; store_fin = 1'b1; #1;
        checks++;
        if (dut2.occ_q !== 2'd2) begin
            errors++; $display("FAIL sim_occ: got %0d want 2", dut2.occ_q);
        end
        checks++;
        if (obs2 !== ev(1, 3, 1, 2, 0)) begin
            errors++; $display("FAIL sim_both2: got %h want %h", obs2, ev(1, 3, 1, 2, 0));
        end
        next_cycle(); compute_fin = 1'b1; store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 1, 3, 0)) begin
            errors++; $display("FAIL sim_both3: got %h want %h", obs2, ev(0, 0, 1, 3, 0));
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL sim_fin: got %h want %h", obs2, ev(0, 0, 0, 0, 1));
        end
        next_cycle(); #1;
        checks++;
        if ({busy2, err2} !== 2'b00) begin
            errors++; $display("FAIL sim_end: busy/err got %b want 00", {busy2, err2});
        end
    endtask

    task automatic test_protocol();
        do_reset();
        store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== 35'd0) begin
            errors++; $display("FAIL proto_spur_out: got %h want 0", obs2);
        end
        next_cycle(); #1;
        checks++;
        if ({err2, busy2} !== 2'b10) begin
            errors++; $display("FAIL proto_err_set: err/busy got %b want 10", {err2, busy2});
        end
        n_chunks = 16'd2; conv_start = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL proto_start: got %h want %h", obs2, ev(1, 0, 0, 0, 0));
        end
        next_cycle(); n_chunks = 16'd7; conv_start = 1'b1; #1;
        checks++;
        if ({obs2, err2} !== 36'd0) begin
            errors++; $display("FAIL proto_restart: got %h want 0", {obs2, err2});
        end
        next_cycle(); #1;
        checks++;
        if ({err2, busy2} !== 2'b01) begin
            errors++; $display("FAIL proto_run_err: err/busy got %b want 01", {err2, busy2});
        end
        compute_fin = 1'b1; #1;
        next_cycle(); compute_fin = 1'b1; #1;
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 1, 1, 0)) begin
            errors++; $display("FAIL proto_store1: got %h want %h", obs2, ev(0, 0, 1, 1, 0));
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL proto_fin_n2: got %h want %h", obs2, ev(0, 0, 0, 0, 1));
        end
        next_cycle(); #1;
        checks++;
        if ({busy2, err2} !== 2'b00) begin
            errors++; $display("FAIL proto_end: busy/err got %b want 00", {busy2, err2});
        end
    endtask

    task automatic test_reset_mid_layer();
        do_reset();
        n_chunks = 16'd5; conv_start = 1'b1; #1;
        next_cycle(); compute_fin = 1'b1; #1;
        next_cycle(); compute_fin = 1'b1; store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 2, 1, 1, 0)) begin
            errors++; $display("FAIL mid_pre: got %h want %h", obs2, ev(1, 2, 1, 1, 0));
        end
        next_cycle(); reset = 1'b1; #1;
        next_cycle(); reset = 1'b0; #1;
        checks++;
        if ({obs2, busy2, err2} !== 37'd0) begin
            errors++; $display("FAIL mid_cleared: got %h want 0", {obs2, busy2, err2});
        end
        compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== 35'd0) begin
            errors++; $display("FAIL mid_late_cf: got %h want 0", obs2);
        end
        next_cycle(); #1;
        checks++;
        if (err2 !== 1'b1) begin
            errors++; $display("FAIL mid_late_err: got %b want 1", err2);
        end
        n_chunks = 16'd1; conv_start = 1'b1; #1;
        checks++;
        if (obs2 !== ev(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL mid_new_c0: got %h want %h", obs2, ev(1, 0, 0, 0, 0));
        end
        next_cycle(); compute_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 1, 0, 0)) begin
            errors++; $display("FAIL mid_new_s0: got %h want %h", obs2, ev(0, 0, 1, 0, 0));
        end
        next_cycle(); store_fin = 1'b1; #1;
        checks++;
        if (obs2 !== ev(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL mid_new_fin: got %h want %h", obs2, ev(0, 0, 0, 0, 1));
        end
        next_cycle(); #1;
        checks++;
        if ({busy2, err2} !== 2'b00) begin
            errors++; $display("FAIL mid_end: busy/err got %b want 00", {busy2, err2});
        end
    endtask

    initial begin
        reset       = 1'b1;
        n_chunks    = '0;
        conv_start  = 1'b0;
        compute_fin = 1'b0;
        store_fin   = 1'b0;
        test_reset();
        test_serial();
        test_overlap();
        test_zero_chunks();
        test_simultaneous();
        test_protocol();
        test_reset_mid_layer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule
